// File: rtl/matrix_mult_ctrl.sv
// matrix_mult_ctrl: control path for the ROWxCOL systolic matrix multiplier.
// Sequences weight load, input issue and psum/output addressing for one job.
package matrix_mult_pkg;
  localparam int unsigned CFG_ROW    = 4;
  localparam int unsigned CFG_W_SIZE = 256;
  localparam int unsigned CFG_I_SIZE = 256;
  localparam int unsigned CFG_O_SIZE = 256;
  localparam int unsigned CFG_WR_W   = (CFG_ROW > 1) ? $clog2(CFG_ROW) : 1;
  localparam int unsigned CFG_W_AW   = $clog2(CFG_W_SIZE);
  localparam int unsigned CFG_I_AW   = $clog2(CFG_I_SIZE);
  localparam int unsigned CFG_O_AW   = $clog2(CFG_O_SIZE);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    IN     = 3'd2,
    IN_OUT = 3'd3,
    OUT    = 3'd4,
    DONE   = 3'd5
  } state_struct;

  // Row counts are encoded minus one: 0 means a single row.
  typedef struct packed {
    logic                accum_en;
    logic [CFG_O_AW-1:0] o_offset_w;
    logic [CFG_O_AW-1:0] psum_offset;
    logic [CFG_I_AW-1:0] i_offset;
    logic [CFG_I_AW-1:0] i_rows;
    logic [CFG_W_AW-1:0] w_offset;
    logic [CFG_WR_W-1:0] w_rows;
  } data_config_struct;
endpackage

// state  | meaning
// IDLE   | waiting for start
// LOAD   | reading weight rows 0..w_rows
// IN     | issuing input rows, no result out yet
// IN_OUT | issuing input rows while results are written
// OUT    | draining remaining results
// DONE   | one-cycle completion pulse
module matrix_mult_ctrl
  import matrix_mult_pkg::*;
#(
  parameter int unsigned ROW    = 4,
  parameter int unsigned COL    = 4,
  parameter int unsigned W_SIZE = 256,
  parameter int unsigned I_SIZE = 256,
  parameter int unsigned O_SIZE = 256,
  parameter int unsigned LAT    = 8,
  localparam int unsigned WR_W  = (ROW > 1) ? $clog2(ROW) : 1,
  localparam int unsigned W_AW  = $clog2(W_SIZE),
  localparam int unsigned I_AW  = $clog2(I_SIZE),
  localparam int unsigned O_AW  = $clog2(O_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  data_config_struct cfg,
  output state_struct       state,
  output logic              busy,
  output logic              done,
  output logic              w_ren,
  output logic [W_AW-1:0]   w_addr,
  output logic              weight_en,
  output logic              i_ren,
  output logic [I_AW-1:0]   i_addr,
  output logic              psum_ren,
  output logic [O_AW-1:0]   psum_addr,
  output logic              o_wen,
  output logic [O_AW-1:0]   o_addr
);
  if (LAT < 2 || ROW < 1 || COL < 1) begin : g_bad_params
    $error("matrix_mult_ctrl: needs LAT >= 2 and ROW, COL >= 1");
  end

  // Phase counter: cycles since the first input issue, spans the whole drain.
  localparam int unsigned DW = $clog2(I_SIZE + LAT + 2);
  typedef logic [DW-1:0] ph_t;

  state_struct       state_nxt;
  data_config_struct cfg_q, cfg_nxt;
  logic [WR_W-1:0]   k_q, k_nxt;
  ph_t               d_q, d_nxt;
  ph_t               rows_last;
  logic              phase_nxt;
  logic              busy_nxt, done_nxt, w_ren_nxt, i_ren_nxt, psum_ren_nxt, o_wen_nxt;
  logic [W_AW-1:0]   w_addr_nxt;
  logic [I_AW-1:0]   i_addr_nxt;
  logic [O_AW-1:0]   psum_addr_nxt, o_addr_nxt;

  always_comb begin
    state_nxt = state;
    cfg_nxt   = cfg_q;
    k_nxt     = k_q;
    d_nxt     = d_q;
    rows_last = ph_t'(cfg_q.i_rows);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          cfg_nxt   = cfg;
          k_nxt     = '0;
          d_nxt     = '0;
        end
      end
      LOAD: begin
        if (k_q == WR_W'(cfg_q.w_rows)) begin
          state_nxt = IN;
          d_nxt     = '0;
        end else begin
          k_nxt = k_q + 1'b1;
        end
      end
      IN, IN_OUT, OUT: begin
        d_nxt = d_q + 1'b1;
        if (d_nxt <= rows_last)
          state_nxt = (d_nxt >= ph_t'(LAT)) ? IN_OUT : IN;
        else if (d_nxt <= rows_last + ph_t'(LAT))
          state_nxt = OUT;
        else
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are computed from next-state values so they can be registered.
    phase_nxt     = state_nxt inside {IN, IN_OUT, OUT};
    busy_nxt      = state_nxt != IDLE;
    done_nxt      = state_nxt == DONE;
    w_ren_nxt     = state_nxt == LOAD;
    w_addr_nxt    = w_ren_nxt ? cfg_nxt.w_offset + W_AW'(k_nxt) : '0;
    i_ren_nxt     = state_nxt inside {IN, IN_OUT};
    i_addr_nxt    = i_ren_nxt ? cfg_q.i_offset + I_AW'(d_nxt) : '0;
    o_wen_nxt     = phase_nxt && (d_nxt >= ph_t'(LAT));
    o_addr_nxt    = o_wen_nxt ? cfg_q.o_offset_w + O_AW'(d_nxt - ph_t'(LAT)) : '0;
    // psum read leads the matching write by one cycle so data lines up.
    psum_ren_nxt  = cfg_q.accum_en && phase_nxt && (d_nxt >= ph_t'(LAT - 1))
                    && (d_nxt <= rows_last + ph_t'(LAT - 1));
    psum_addr_nxt = psum_ren_nxt ? cfg_q.psum_offset + O_AW'(d_nxt - ph_t'(LAT - 1)) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cfg_q     <= '0;
      k_q       <= '0;
      d_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_ren     <= 1'b0;
      w_addr    <= '0;
      weight_en <= 1'b0;
      i_ren     <= 1'b0;
      i_addr    <= '0;
      psum_ren  <= 1'b0;
      psum_addr <= '0;
      o_wen     <= 1'b0;
      o_addr    <= '0;
    end else begin
      state     <= state_nxt;
      cfg_q     <= cfg_nxt;
      k_q       <= k_nxt;
      d_q       <= d_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      w_ren     <= w_ren_nxt;
      w_addr    <= w_addr_nxt;
      weight_en <= w_ren;
      i_ren     <= i_ren_nxt;
      i_addr    <= i_addr_nxt;
      psum_ren  <= psum_ren_nxt;
      psum_addr <= psum_addr_nxt;
      o_wen     <= o_wen_nxt;
      o_addr    <= o_addr_nxt;
    end
  end
endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Testbench for matrix_mult_ctrl: table of jobs, a reset-mid-job sequence and
// random jobs, each checked per cycle against a job-timeline model.
module tb_matrix_mult_ctrl;
  import matrix_mult_pkg::*;

  localparam int LAT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  data_config_struct cfg;
  state_struct       state;
  logic              busy, done, w_ren, weight_en, i_ren, psum_ren, o_wen;
  logic [7:0]        w_addr, i_addr, psum_addr, o_addr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       busy;
    logic       done;
    logic       w_ren;
    logic [7:0] w_addr;
    logic       weight_en;
    logic       i_ren;
    logic [7:0] i_addr;
    logic       psum_ren;
    logic [7:0] psum_addr;
    logic       o_wen;
    logic [7:0] o_addr;
  } snap_t;

  typedef struct {
    string             name;
    data_config_struct cf;
    bit                hold;
    bit                scramble;
    int                exp_len;
    bit                exp_inout;
  } vec_t;

  vec_t vecs[9];

  matrix_mult_ctrl #(
    .ROW(4), .COL(4), .W_SIZE(256), .I_SIZE(256), .O_SIZE(256), .LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg(cfg), .state(state),
    .busy(busy), .done(done), .w_ren(w_ren), .w_addr(w_addr),
    .weight_en(weight_en), .i_ren(i_ren), .i_addr(i_addr),
    .psum_ren(psum_ren), .psum_addr(psum_addr), .o_wen(o_wen), .o_addr(o_addr)
  );

  always #5 clk = ~clk;

  function automatic data_config_struct mkcfg(input int wr, input int wo, input int ir,
                                              input int io, input int po, input int oo,
                                              input bit acc);
    data_config_struct c;
    c = '0;
    c.w_rows      = 2'(wr);
    c.w_offset    = 8'(wo);
    c.i_rows      = 8'(ir);
    c.i_offset    = 8'(io);
    c.psum_offset = 8'(po);
    c.o_offset_w  = 8'(oo);
    c.accum_en    = acc;
    return c;
  endfunction

  function automatic vec_t mkvec(input string nm, input data_config_struct cf, input bit hold,
                                 input bit scr, input int len, input bit inout_exp);
    vec_t v;
    v.name = nm; v.cf = cf; v.hold = hold; v.scramble = scr;
    v.exp_len = len; v.exp_inout = inout_exp;
    return v;
  endfunction

  function automatic data_config_struct rand_cfg();
    data_config_struct c;
    c.w_rows      = 2'($urandom);
    c.w_offset    = 8'($urandom);
    c.i_rows      = 8'($urandom_range(0, 40));
    c.i_offset    = 8'($urandom);
    c.psum_offset = 8'($urandom);
    c.o_offset_w  = 8'($urandom);
    c.accum_en    = 1'($urandom);
    return c;
  endfunction

  // Expected outputs at cycle c of a job, c=0 being the first LOAD cycle.
  function automatic snap_t model(input data_config_struct cf, input int c);
    snap_t s;
    int t0, nr, jl;
    s  = '0;
    t0 = int'(cf.w_rows) + 1;
    nr = int'(cf.i_rows) + 1;
    jl = (int'(cf.w_rows) + 1) + (LAT + int'(cf.i_rows) + 1);
    if (c < 0 || c > jl) return s;
    s.busy = 1'b1;
    s.done = (c == jl);
    if (c < t0) begin
      s.w_ren  = 1'b1;
      s.w_addr = cf.w_offset + 8'(c);
    end
    s.weight_en = (c >= 1 && c <= t0);
    if (c >= t0 && c < t0 + nr) begin
      s.i_ren  = 1'b1;
      s.i_addr = cf.i_offset + 8'(c - t0);
    end
    if (c >= t0 + LAT && c < t0 + LAT + nr) begin
      s.o_wen  = 1'b1;
      s.o_addr = cf.o_offset_w + 8'(c - t0 - LAT);
    end
    if (cf.accum_en && c >= t0 + LAT - 1 && c < t0 + LAT - 1 + nr) begin
      s.psum_ren  = 1'b1;
      s.psum_addr = cf.psum_offset + 8'(c - t0 - LAT + 1);
    end
    if (c < t0)           s.st = LOAD;
    else if (s.i_ren)     s.st = (c >= t0 + LAT) ? IN_OUT : IN;
    else if (c < jl)      s.st = OUT;
    else                  s.st = DONE;
    return s;
  endfunction

  function automatic snap_t sample();
    snap_t s;
    s.st        = state;
    s.busy      = busy;
    s.done      = done;
    s.w_ren     = w_ren;
    s.w_addr    = w_ren ? w_addr : 8'd0;
    s.weight_en = weight_en;
    s.i_ren     = i_ren;
    s.i_addr    = i_ren ? i_addr : 8'd0;
    s.psum_ren  = psum_ren;
    s.psum_addr = psum_ren ? psum_addr : 8'd0;
    s.o_wen     = o_wen;
    s.o_addr    = o_wen ? o_addr : 8'd0;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d busy=%0b done=%0b w=%0b@%0d wen=%0b i=%0b@%0d p=%0b@%0d o=%0b@%0d",
                     s.st, s.busy, s.done, s.w_ren, s.w_addr, s.weight_en, s.i_ren, s.i_addr,
                     s.psum_ren, s.psum_addr, s.o_wen, s.o_addr);
  endfunction

  task automatic check_snap(input string nm, input int c, input snap_t act, input snap_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got {%s} expected {%s}", nm, c, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_job(input string nm, input data_config_struct cf, input bit hold,
                         input bit scramble, input int exp_len, input bit exp_inout);
    int    jl, ni, no, np, nw, nd, dc;
    bit    seen_io;
    snap_t a;
    jl = (int'(cf.w_rows) + 1) + (LAT + int'(cf.i_rows) + 1);
    ni = 0; no = 0; np = 0; nw = 0; nd = 0; dc = -1; seen_io = 1'b0;
    @(negedge clk);
    cfg   = cf;
    start = 1'b1;
    for (int c = 0; c <= jl + 1; c++) begin
      @(posedge clk);
      #1;
      a = sample();
      check_snap(nm, c, a, model(cf, c));
      ni += int'(a.i_ren);
      no += int'(a.o_wen);
      np += int'(a.psum_ren);
      nw += int'(a.weight_en);
      nd += int'(a.done);
      if (a.done && dc < 0) dc = c;
      if (a.st == IN_OUT) seen_io = 1'b1;
      @(negedge clk);
      if (!hold || c >= jl) start = 1'b0;
      if (scramble) cfg = rand_cfg();
    end
    start = 1'b0;
    check_int({nm, " i_ren pulses"}, ni, int'(cf.i_rows) + 1);
    check_int({nm, " o_wen pulses"}, no, int'(cf.i_rows) + 1);
    check_int({nm, " psum_ren pulses"}, np, cf.accum_en ? int'(cf.i_rows) + 1 : 0);
    check_int({nm, " weight_en pulses"}, nw, int'(cf.w_rows) + 1);
    check_int({nm, " done pulses"}, nd, 1);
    check_int({nm, " done cycle"}, dc, exp_len);
    check_int({nm, " in_out seen"}, int'(seen_io), int'(exp_inout));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    data_config_struct rc;
    bit                rh, rs;
    int                rlen;

    // name, cfg(w_rows, w_off, i_rows, i_off, psum_off, o_off, accum), hold, scramble, len, in_out
    vecs[0] = mkvec("basic",    mkcfg(3,   8,  15,   0,   0,   0, 1'b0), 1'b0, 1'b0,  28, 1'b1);
    vecs[1] = mkvec("short",    mkcfg(1,  20,   2,   5,   0,  60, 1'b0), 1'b0, 1'b0,  13, 1'b0);
    vecs[2] = mkvec("accum",    mkcfg(0,   0,   3,   0,  40, 100, 1'b1), 1'b0, 1'b0,  13, 1'b0);
    vecs[3] = mkvec("no_accum", mkcfg(0,   0,   3,   0,  40, 100, 1'b0), 1'b0, 1'b0,  13, 1'b0);
    vecs[4] = mkvec("wrap",     mkcfg(2, 254,   3, 254, 253, 255, 1'b1), 1'b0, 1'b0,  15, 1'b0);
    vecs[5] = mkvec("hold_cfg", mkcfg(2,  30,   9,  17,   9,  77, 1'b1), 1'b1, 1'b1,  21, 1'b1);
    vecs[6] = mkvec("i_eq_lat", mkcfg(3,   0,   8,   0,   0,   0, 1'b0), 1'b0, 1'b0,  21, 1'b1);
    vecs[7] = mkvec("i_lat_m1", mkcfg(0,   0,   7,   0,   0,   0, 1'b0), 1'b0, 1'b0,  17, 1'b0);
    vecs[8] = mkvec("max_rows", mkcfg(3, 100, 255,   1,   2,   3, 1'b1), 1'b0, 1'b0, 268, 1'b1);

    rst_n = 1'b0;
    start = 1'b0;
    cfg   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_snap("reset", 0, sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_snap("idle_after_reset", 0, sample(), '0);
    end

    // Reset asserted in the middle of LOAD must clear everything before the next edge.
    @(negedge clk);
    cfg   = mkcfg(3, 8, 15, 0, 0, 0, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1;
    check_int("pre_reset_state", int'(state), int'(LOAD));
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_snap("reset_mid_load", 0, sample(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check_snap("no_done_after_reset", 0, sample(), '0);
    end

    for (int v = 0; v < 9; v++)
      run_job(vecs[v].name, vecs[v].cf, vecs[v].hold, vecs[v].scramble,
              vecs[v].exp_len, vecs[v].exp_inout);

    for (int r = 0; r < 25; r++) begin
      rc   = rand_cfg();
      rh   = 1'($urandom);
      rs   = 1'($urandom);
      rlen = (int'(rc.w_rows) + 1) + (LAT + int'(rc.i_rows) + 1);
      run_job($sformatf("rand%0d", r), rc, rh, rs, rlen, int'(rc.i_rows) + 1 > LAT);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
